// File: rtl/neuron_mac_sequencer.sv
// Four-neuron fully-connected layer: streams weights from a registered memory,
// multiply-accumulates on one shared multiplier, then presents saturated results.
module neuron_mac_lane #(
  parameter int DW    = 16,
  parameter int FRAC  = 6,
  parameter int ACC_W = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   cap_en,
  input  logic                   cap_bias,
  input  logic                   fin,
  input  logic signed [2*DW-1:0] prod,
  input  logic [DW-1:0]          bias_in,
  output logic [DW-1:0]          r
);
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sh;
  logic [DW-1:0]           bias;
  logic [ACC_W:0]          sum;
  logic [ACC_W-DW+1:0]     hi;
  logic [DW-1:0]           sat;

  // Result fits in DW bits only when every bit above the DW-1 sign bit agrees with it.
  always_comb begin
    acc_sh = acc >>> FRAC;
    sum    = {acc_sh[ACC_W-1], acc_sh} + {{(ACC_W+1-DW){bias[DW-1]}}, bias};
    hi     = sum[ACC_W:DW-1];
    if ((&hi) || !(|hi)) sat = sum[DW-1:0];
    else                 sat = sum[ACC_W] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      bias <= '0;
      r    <= '0;
    end else begin
      if (clr)         acc <= '0;
      else if (cap_en) acc <= acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
      if (clr)                    bias <= '0;
      else if (cap_en && cap_bias) bias <= bias_in;
      if (fin) r <= sat;
    end
  end
endmodule

module neuron_mac_sequencer #(
  parameter int DW    = 16,
  parameter int FRAC  = 6,
  parameter int ACC_W = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          start_ready,
  input  logic [2:0]    layer,
  input  logic [2:0]    in_count,
  input  logic [4*DW-1:0] x_data,
  output logic [5:0]    mem_n,
  output logic [5:0]    mem_i,
  output logic          mem_wt_en,
  output logic          mem_bias_en,
  input  logic [DW-1:0] mem_wt_data,
  input  logic [DW-1:0] mem_bias_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_idx,
  output logic          busy
);
  typedef enum logic [2:0] {IDLE, FETCH, GAP, FINAL, OUT} state_t;

  state_t                 state, nxt;
  logic [1:0]             beat, i, n_last, oidx, cap_j;
  logic                   cap_vld, accept;
  logic [2:0]             layer_q;
  logic [3:0][DW-1:0]     x_q;
  logic [3:0][DW-1:0]     r;
  logic [3:0]             cap_en;
  logic signed [2*DW-1:0] prod;

  assign accept      = (state == IDLE) && start;
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign mem_wt_en   = (state == FETCH);
  assign mem_bias_en = (state == FETCH) && (i == 2'd0);
  assign mem_n       = {3'b0, layer_q};
  assign mem_i       = {4'b0, i};
  assign out_valid   = (state == OUT);
  assign out_idx     = oidx;
  assign out_data    = (state == OUT) ? r[oidx] : '0;

  // Single shared multiplier; memory data for beat j arrives the cycle after it.
  assign prod = $signed(x_q[i]) * $signed(mem_wt_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = FETCH;
      FETCH:   if (beat == 2'd3) nxt = GAP;
      GAP:     nxt = (i == n_last) ? FINAL : FETCH;
      FINAL:   nxt = OUT;
      OUT:     if (out_ready && oidx == 2'd3) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat    <= '0;
      i       <= '0;
      n_last  <= '0;
      oidx    <= '0;
      cap_vld <= 1'b0;
      cap_j   <= '0;
      layer_q <= '0;
      x_q     <= '0;
    end else begin
      beat    <= (state == FETCH) ? beat + 2'd1 : 2'd0;
      cap_vld <= (state == FETCH);
      cap_j   <= beat;
      if (accept) begin
        layer_q <= layer;
        x_q     <= x_data;
        i       <= '0;
        oidx    <= '0;
        n_last  <= (in_count == 3'd0 || in_count > 3'd4) ? 2'd3 : 2'(in_count - 3'd1);
      end
      if (state == GAP && i != n_last) i <= i + 2'd1;
      if (state == OUT && out_ready)   oidx <= oidx + 2'd1;
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_lane
    assign cap_en[j] = cap_vld && (cap_j == 2'(j));
    neuron_mac_lane #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (accept),
      .cap_en   (cap_en[j]),
      .cap_bias (i == 2'd0),
      .fin      (state == FINAL),
      .prod     (prod),
      .bias_in  (mem_bias_data),
      .r        (r[j])
    );
  end
endmodule

// File: doc/neuron_mac_sequencer.md
NEURON_MAC_SEQUENCER -- requirements
Module: neuron_mac_sequencer

Interface
REQ-001 Parameter DW, 16, signed fixed-point word width of activations, weights, biases and results.
REQ-002 Parameter FRAC, 6, fractional bits of every DW word (Q10.6; 1.0 = 64).
REQ-003 Parameter ACC_W, 40, signed accumulator width per neuron.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  request to evaluate one 4-neuron layer.
REQ-008 start_ready  out  1  high only in IDLE; start accepted when start && start_ready.
REQ-009 layer  in  3  layer index, sampled at start acceptance.
REQ-010 in_count  in  3  number of inputs 1..4, sampled at acceptance; 0 or >4 SHALL be treated as 4.
REQ-011 x_data  in  4*DW  input activations, x[i] = x_data[DW*i +: DW], sampled at acceptance.
REQ-012 mem_n  out  6  weight/bias memory layer select: {3'b0, latched layer}.
REQ-013 mem_i  out  6  weight memory input select: {4'b0, current input index}.
REQ-014 mem_wt_en  out  1  weight read enable; memory returns neuron j's word one cycle after the j-th consecutive enabled cycle; its beat counter clears when low.
REQ-015 mem_bias_en  out  1  bias read enable; bias for neuron j returned on the same cycle as weight beat j.
REQ-016 mem_wt_data  in  DW  registered weight word from memory.
REQ-017 mem_bias_data  in  DW  registered bias word from memory.
REQ-018 out_valid  out  1  result j presented.
REQ-019 out_ready  in  1  downstream (activation stage) accepts when out_valid && out_ready.
REQ-020 out_data  out  DW  saturated neuron result.
REQ-021 out_idx  out  2  neuron index of out_data.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 States SHALL be IDLE, FETCH, GAP, FINAL, OUT.
REQ-024 IDLE->FETCH on start acceptance: latch layer, in_count, x[0..3]; clear acc[0..3]; set i=0.
REQ-025 FETCH: mem_wt_en=1 for exactly 4 consecutive cycles at mem_i=i; mem_bias_en=1 in these cycles only when i=0; then GAP.
REQ-026 GAP: mem_wt_en=0 for exactly one cycle, clearing the memory beat counter; then FETCH with i+1 if i+1<in_count, else FINAL.
REQ-027 Capture: in the cycle after each enabled beat j (covering the first 3 FETCH cycles after the first and the following GAP), acc[j] += sign-extended x[i]*mem_wt_data (full 2*DW-bit signed product, Q.12); when i=0, also latch bias[j]=mem_bias_data.
REQ-028 One shared signed multiplier SHALL be used; one MAC per cycle.
REQ-029 FINAL (1 cycle): r[j] = (acc[j] >>> FRAC, arithmetic shift, truncation toward -inf) + sign-extended bias[j], saturated to [0x8000, 0x7FFF]; store r[0..3].
REQ-030 OUT: present r[0..3] in order, out_idx=0..3; out_valid held and out_data/out_idx stable until accepted; advance one index per handshake.
REQ-031 After the handshake of index 3, the next state SHALL be IDLE, with start_ready asserted the following cycle; start is never accepted in the same cycle as that handshake.
REQ-032 Latency for in_count=N with no backpressure: start accepted at cycle 0, first out_valid at cycle 5N+2.
REQ-033 start while busy SHALL be ignored; layer, in_count and x_data changes after acceptance SHALL have no effect.
REQ-034 mem_n SHALL be stable from acceptance to FINAL; mem_i SHALL change only on a GAP->FETCH transition.

Reset
REQ-035 On rst_n low, asynchronously: state IDLE; start_ready=1 once rst_n is released; busy=0; mem_wt_en=0; mem_bias_en=0; mem_n=0; mem_i=0; out_valid=0; out_data=0; out_idx=0; acc, bias, r, x cleared.
REQ-036 Reset asserted mid-FETCH or mid-OUT SHALL abort the layer; no result SHALL be presented after release until a new start.

Verification
REQ-037 Basic: layer=0, in_count=1, x0=64; memory w(0,0,*)={64,128,0,0}, bias(0,*)={120,89,0,0} -> out_data 184,217,0,0, idx 0..3, first out_valid at cycle 7.
REQ-038 Negative/truncation: x0=64, w=0xFFF0, bias 0 -> 0xFFF0; x0=0xFFFF, w=1 -> 0xFFFF; x0=1, w=1 -> 0x0000.
REQ-039 Saturation: in_count=4, all x=0x7FFF, all w=0x7FFF, bias 0x7FFF -> all outputs 0x7FFF; all x=0x8000, w=0x7FFF, bias 0x8000 -> all 0x8000.
REQ-040 Protocol: in_count=4 -> exactly four 4-cycle mem_wt_en bursts separated by 1-cycle gaps, mem_i=0,1,2,3, mem_bias_en only in burst 0; in_count=0 behaves as 4.
REQ-041 Backpressure: out_ready low 3 cycles per index -> out_data/out_idx stable, no skipped or duplicated index; start pulsed during OUT is ignored.
REQ-042 Reset mid-FETCH (cycle 8 of in_count=4) -> outputs reach reset values immediately; a following start returns correct results for the new layer.
